// File: rtl/class2_feature_loader.sv
// class2_feature_loader: assembles a streamed feature vector, waits for the tree to settle, returns its class bit
module class2_feature_loader #(
    parameter int FEAT_W   = 51,
    parameter int CHUNK_W  = 8,
    parameter int EVAL_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [CHUNK_W-1:0] s_data,
    input  logic               s_last,
    output logic [FEAT_W-1:0]  feat,
    input  logic               tree_o,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_class,
    output logic               err_len,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         err_cnt
);
    localparam int NBEATS = (FEAT_W + CHUNK_W - 1) / CHUNK_W;
    localparam int IDX_W  = NBEATS > 1 ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {LOAD, DRAIN, EVAL, OUT} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [FEAT_W-1:0] feat_q, feat_d;
    logic              m_class_q, m_class_d;
    logic              err_len_q, err_len_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              last_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            feat_q      <= '0;
            m_class_q   <= 1'b0;
            err_len_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            feat_q      <= feat_d;
            m_class_q   <= m_class_d;
            err_len_q   <= err_len_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign s_ready   = state_q == LOAD || state_q == DRAIN;
    assign m_valid   = state_q == OUT;
    assign feat      = feat_q;
    assign m_class   = m_class_q;
    assign err_len   = err_len_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign last_idx  = idx_q == IDX_W'(NBEATS - 1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        feat_d      = feat_q;
        m_class_d   = m_class_q;
        err_len_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            LOAD: if (s_valid) begin
                // bits of the final beat beyond FEAT_W simply have no destination
                for (int b = 0; b < FEAT_W; b++)
                    if (b / CHUNK_W == int'(idx_q)) feat_d[b] = s_data[b % CHUNK_W];
                idx_d = (s_last || last_idx) ? '0 : idx_q + IDX_W'(1);
                if (s_last && last_idx) begin
                    state_d = EVAL;
                    cnt_d   = '0;
                end else if (s_last || last_idx) begin
                    err_len_d = 1'b1;
                    err_cnt_d = err_cnt_q + {7'd0, ~&err_cnt_q};
                    state_d   = s_last ? LOAD : DRAIN;
                end
            end
            DRAIN: if (s_valid && s_last) state_d = LOAD;
            EVAL: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(EVAL_LAT)) begin
                    state_d     = OUT;
                    m_class_d   = tree_o;
                    frame_cnt_d = frame_cnt_q + {15'd0, ~&frame_cnt_q};
                end
            end
            default: if (m_ready) state_d = LOAD;
        endcase
    end
endmodule
